// File: rtl/synth_cfg_pkg.sv
// Shared definitions for the synth configuration-register write path (SPI receiver and cfg register file).
package synth_cfg_pkg;

    localparam int unsigned CFG_WORDS           = 8;
    localparam int unsigned CEIL_LOG2_CFG_WORDS = $clog2(CFG_WORDS);

    localparam int unsigned CMD_BITS      = 8;
    localparam int unsigned CMD_WRITE_BIT = 7;
    localparam int unsigned CMD_AINC_BIT  = 6;
    localparam int unsigned CMD_ADDR_MSB  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } rx_state_t;

    // A command is accepted only as a write with the reserved field clear.
    function automatic logic cmd_valid(input logic [CMD_BITS-1:0] cmd);
        return cmd[CMD_WRITE_BIT] && (cmd[CMD_AINC_BIT-1:CMD_ADDR_MSB+1] == '0);
    endfunction

endpackage

// File: rtl/synth_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with registered level and edge-detect outputs.
module synth_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              rise_q;
    logic              fall_q;

    // Edges are computed from the stage feeding the output, so they line up with the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
            fall_q <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/synth_spi_cfg_rx.sv
// SPI mode-0 slave: deserialises host command/data frames into cfg register write strobes.
module synth_spi_cfg_rx #(
    parameter int unsigned CEIL_LOG2_CFG_WORDS = synth_cfg_pkg::CEIL_LOG2_CFG_WORDS,
    parameter int unsigned WORD_BITS           = 16,
    parameter int unsigned SYNC_STAGES         = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           spi_sck,
    input  logic                           spi_cs_n,
    input  logic                           spi_mosi,
    output logic [1:0]                     cfg_we,
    output logic [CEIL_LOG2_CFG_WORDS-1:0] cfg_w_addr,
    output logic [WORD_BITS-1:0]           cfg_w_data,
    output logic                           busy,
    output logic                           frame_err
);

    import synth_cfg_pkg::*;

    localparam int unsigned AW    = CEIL_LOG2_CFG_WORDS;
    localparam int unsigned CNT_W = $clog2(WORD_BITS + 1);

    logic sck_s, sck_rise, sck_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    synth_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_sck),
        .level (sck_s),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    synth_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_cs_n),
        .level (cs_n_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as the sck path so mosi is sampled at the synchronised sck rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic                 ainc_q, ainc_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [1:0]           cfg_we_q, cfg_we_d;
    logic [AW-1:0]        cfg_w_addr_q, cfg_w_addr_d;
    logic [WORD_BITS-1:0] cfg_w_data_q, cfg_w_data_d;
    logic                 busy_q, busy_d;
    logic                 frame_err_q, frame_err_d;

    logic [CMD_BITS-1:0]  cmd_c;
    logic [WORD_BITS-1:0] word_c;

    assign cmd_c  = {shift_q[CMD_BITS-2:0], mosi_s};
    assign word_c = {shift_q[WORD_BITS-2:0], mosi_s};

    logic unused_sigs;
    assign unused_sigs = ^{sck_s, sck_fall, shift_q[WORD_BITS-1]};

    // Next-state and output logic; cs_rise takes priority over a coincident sck_rise.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ainc_d       = ainc_q;
        addr_d       = addr_q;
        cfg_we_d     = 2'b00;
        cfg_w_addr_d = cfg_w_addr_q;
        cfg_w_data_d = cfg_w_data_q;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sck_rise) begin
                    shift_d = word_c;
                    if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (cmd_valid(cmd_c)) begin
                            state_d = DATA;
                            addr_d  = AW'(cmd_c[CMD_ADDR_MSB:0]);
                            ainc_d  = cmd_c[CMD_AINC_BIT];
                        end else begin
                            state_d     = DISCARD;
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sck_rise) begin
                    shift_d = word_c;
                    if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
                        cfg_we_d     = 2'b11;
                        cfg_w_addr_d = addr_q;
                        cfg_w_data_d = word_c;
                        addr_d       = addr_q + AW'(ainc_q);
                        bit_cnt_d    = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            DISCARD: begin
                if (cs_n_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = DISCARD;
        endcase

        busy_d = (state_d == CMD) || (state_d == DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DISCARD;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ainc_q       <= 1'b0;
            addr_q       <= '0;
            cfg_we_q     <= 2'b00;
            cfg_w_addr_q <= '0;
            cfg_w_data_q <= '0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ainc_q       <= ainc_d;
            addr_q       <= addr_d;
            cfg_we_q     <= cfg_we_d;
            cfg_w_addr_q <= cfg_w_addr_d;
            cfg_w_data_q <= cfg_w_data_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign cfg_we     = cfg_we_q;
    assign cfg_w_addr = cfg_w_addr_q;
    assign cfg_w_data = cfg_w_data_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_synth_spi_cfg_rx.sv
// Scoreboard bench for synth_spi_cfg_rx: directed SPI frames, expected writes queued, monitor compares.
module tb_synth_spi_cfg_rx;

    localparam int unsigned AW   = 3;
    localparam int unsigned WB   = 16;
    localparam int unsigned SYNC = 2;
    localparam int          HALF = 50;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WB-1:0] data;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          spi_sck;
    logic          spi_cs_n;
    logic          spi_mosi;
    logic [1:0]    cfg_we;
    logic [AW-1:0] cfg_w_addr;
    logic [WB-1:0] cfg_w_data;
    logic          busy;
    logic          frame_err;

    synth_spi_cfg_rx #(
        .CEIL_LOG2_CFG_WORDS (AW),
        .WORD_BITS           (WB),
        .SYNC_STAGES         (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .cfg_we     (cfg_we),
        .cfg_w_addr (cfg_w_addr),
        .cfg_w_data (cfg_w_data),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];
    int  err_seen = 0;
    int  err_exp  = 0;
    int  cyc      = 0;
    int  sck_cyc  = 0;
    logic we_prev  = 1'b0;
    logic err_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge spi_sck) sck_cyc <= cyc;

    // Monitor: every write is matched against the head of the expectation queue.
    always @(negedge clk) begin
        if (cfg_we != 2'b00) begin
            wr_t e;
            int  lat;
            lat = cyc - sck_cyc;
            check("cfg_we_value", 32'(cfg_we), 32'h3);
            check("we_one_clk", 32'(we_prev), 32'h0);
            check("write_latency_in_range", 32'(lat >= int'(SYNC + 1) && lat <= int'(SYNC + 2)), 32'h1);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%04h, expected no write at %0t",
                         cfg_w_addr, cfg_w_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(cfg_w_addr), 32'(e.addr));
                check("write_data", 32'(cfg_w_data), 32'(e.data));
            end
        end
        if (frame_err) begin
            err_seen++;
            check("err_one_clk", 32'(err_prev), 32'h0);
        end
        we_prev  <= (cfg_we != 2'b00);
        err_prev <= frame_err;
    end

    task automatic push(input logic [AW-1:0] a, input logic [WB-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        #HALF;
        spi_sck = 1'b1;
        #HALF;
        spi_sck = 1'b0;
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF;
        spi_cs_n = 1'b1;
        #(HALF * 4);
    endtask

    task automatic end_of_test(input string name);
        check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
        check({name, "_frame_err_count"}, 32'(err_seen), 32'(err_exp));
        check({name, "_busy_idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cfg_we", 32'(cfg_we), 32'h0);
        check("rst_cfg_w_addr", 32'(cfg_w_addr), 32'h0);
        check("rst_cfg_w_data", 32'(cfg_w_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        #2;
        rst_n = 1'b1;
        #(HALF * 4);

        // 1: single write, no auto-increment
        cs_low();
        spi_bits(32'h83, 8);
        check("t1_busy_in_frame", 32'(busy), 32'h1);
        push(3'd3, 16'h1234);
        spi_bits(32'h1234, 16);
        cs_high();
        end_of_test("t1");

        // 2: auto-increment with address wrap
        cs_low();
        spi_bits(32'hC6, 8);
        push(3'd6, 16'hAAAA); spi_bits(32'hAAAA, 16);
        push(3'd7, 16'h5555); spi_bits(32'h5555, 16);
        push(3'd0, 16'h0F0F); spi_bits(32'h0F0F, 16);
        cs_high();
        end_of_test("t2");
        check("t2_hold_data", 32'(cfg_w_data), 32'h0F0F);
        check("t2_hold_addr", 32'(cfg_w_addr), 32'h0);

        // 3: fixed address
        cs_low();
        spi_bits(32'h82, 8);
        push(3'd2, 16'h1111); spi_bits(32'h1111, 16);
        push(3'd2, 16'h2222); spi_bits(32'h2222, 16);
        cs_high();
        end_of_test("t3");

        // 4: partial word dropped, then recovery
        cs_low();
        spi_bits(32'h81, 8);
        spi_bits(32'h1FF, 9);
        err_exp++;
        cs_high();
        end_of_test("t4a");
        cs_low();
        spi_bits(32'h80, 8);
        push(3'd0, 16'hBEEF); spi_bits(32'hBEEF, 16);
        cs_high();
        end_of_test("t4b");

        // 5: invalid commands discard the rest of the frame
        cs_low();
        spi_bits(32'h01, 8);
        err_exp++;
        spi_bits(32'h1234, 16);
        check("t5_busy_discard", 32'(busy), 32'h0);
        cs_high();
        end_of_test("t5a");
        cs_low();
        spi_bits(32'h88, 8);
        err_exp++;
        spi_bits(32'hFFFF, 16);
        cs_high();
        end_of_test("t5b");
        cs_low();
        spi_bits(32'h85, 8);
        push(3'd5, 16'h7E57); spi_bits(32'h7E57, 16);
        cs_high();
        end_of_test("t5c");

        // Boundaries: empty frame is clean, truncated command is an error
        cs_low();
        cs_high();
        end_of_test("empty_frame");
        cs_low();
        spi_bits(32'h5, 3);
        err_exp++;
        cs_high();
        end_of_test("short_cmd");

        // 6: reset mid-word with cs low, frame must not be accepted
        cs_low();
        spi_bits(32'h84, 8);
        spi_bits(32'hC0, 8);
        rst_n = 1'b0;
        #HALF;
        check("t6_rst_data", 32'(cfg_w_data), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        #HALF;
        spi_bits(32'hDE, 8);
        check("t6_busy_after_rst", 32'(busy), 32'h0);
        cs_high();
        end_of_test("t6a");
        cs_low();
        spi_bits(32'h84, 8);
        push(3'd4, 16'hC0DE); spi_bits(32'hC0DE, 16);
        cs_high();
        end_of_test("t6b");
        check("t6_hold_addr", 32'(cfg_w_addr), 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
